// File: rtl/can_tx_queue_pkg.sv
// Shared definitions for the CAN transmit path: FSM state encoding,
// packet width shared with the frame controller, and a sizing helper.
package can_tx_queue_pkg;

  localparam int CAN_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/can_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy counter, flush and overflow pulse.
// Shared by the CAN transmit queue and the receive path.
module can_sync_fifo
  import can_tx_queue_pkg::*;
#(
  parameter int WIDTH = CAN_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q];

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    do_pop     = pop && !empty && !flush;
    do_push    = push && (!full || do_pop) && !flush;
    overflow_d = push && full && !do_pop && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; only entries covered by level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/can_tx_queue.sv
// Transmit queue feeding the CAN frame controller: presents the head packet,
// tracks acceptance/completion, and drops frames that exceed the retry budget.
module can_tx_queue
  import can_tx_queue_pkg::*;
#(
  parameter int WIDTH     = CAN_WIDTH,
  parameter int DEPTH     = 4,
  parameter int RETRY_MAX = 16
) (
  input  logic                  GCLK,
  input  logic                  RES_N,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow,
  output logic [WIDTH-1:0]      DIN,
  output logic                  tx_start,
  input  logic                  slot_start,
  input  logic                  tx_ready,
  output logic                  sent,
  output logic                  dropped
);

  localparam int RW = clog2(RETRY_MAX + 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             armed_q, armed_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             sent_q, sent_d;
  logic             dropped_q, dropped_d;
  logic             pop, complete, timeout;
  logic [WIDTH-1:0] head;
  logic             fifo_empty;

  can_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (GCLK),
    .rst_n    (RES_N),
    .flush    (flush),
    .push     (wr_en),
    .wr_data  (wr_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (fifo_empty),
    .level    (level),
    .overflow (overflow)
  );

  assign empty    = fifo_empty;
  assign DIN      = din_q;
  assign tx_start = (state_q == ST_REQ);
  assign sent     = sent_q;
  assign dropped  = dropped_q;

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    armed_d   = armed_q;
    retry_d   = retry_q;
    sent_d    = 1'b0;
    dropped_d = 1'b0;
    pop       = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      armed_d = 1'b0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            din_d   = head;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          armed_d = 1'b0;
          retry_d = '0;
          if (slot_start) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // armed guards against a tx_ready level left high by the previous frame
          complete = armed_q && tx_ready;
          timeout  = slot_start && (retry_q == RW'(RETRY_MAX - 1));
          if (!tx_ready)  armed_d = 1'b1;
          if (slot_start) retry_d = retry_q + RW'(1);
          if (complete || timeout) begin
            pop       = 1'b1;
            sent_d    = complete;
            dropped_d = !complete;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge GCLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      armed_q   <= 1'b0;
      retry_q   <= '0;
      sent_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      armed_q   <= armed_d;
      retry_q   <= retry_d;
      sent_q    <= sent_d;
      dropped_q <= dropped_d;
    end
  end

endmodule
